// File: rtl/fa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fa_pkg
// Description : Shared constants for the registered ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
package fa_pkg;

    localparam int c_WIDTH_DEFAULT = 1;
    localparam int c_WIDTH_MIN     = 1;
    localparam int c_WIDTH_MAX     = 64;

endpackage : fa_pkg
`default_nettype wire

// File: rtl/fa_bh_if.sv
`default_nettype none
// ============================================================================
// Module      : fa_bh_if
// Description : Operand/result bundle for fa_bh (master drives operands).
// Revision    : 1.0 - initial release
// ============================================================================
interface fa_bh_if
    import fa_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  s, c, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output s, c, out_valid
    );

endinterface : fa_bh_if
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : One-bit combinational full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    assign c     = (a & b) | (cin & w_axb);

endmodule : fa_cell
`default_nettype wire

// File: rtl/fa_bh.sv
`default_nettype none
// ============================================================================
// Module      : fa_bh
// Description : WIDTH-bit ripple-carry adder with a single output register.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_bh
    import fa_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] s,
    output logic             c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_out_valid;

    if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX) begin : g_bad_width
        $error("fa_bh: WIDTH out of range");
    end

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_fa_cell (
            .s   (w_sum[i]),
            .c   (w_carry[i+1]),
            .a   (a[i]),
            .b   (b[i]),
            .cin (w_carry[i])
        );
    end

    // Result only loads on accepted operands so garbage on idle cycles never reaches s/c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '0;
            r_c         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s <= w_sum;
                r_c <= w_carry[WIDTH];
            end
        end
    end

    assign s         = r_s;
    assign c         = r_c;
    assign out_valid = r_out_valid;

endmodule : fa_bh
`default_nettype wire

// File: tb/tb_fa_bh.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa_bh
// Description : Self-checking bench for fa_bh at WIDTH = 1, 8 and 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_bh;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fa_bh_if #(.WIDTH(1))  if1  ();
    fa_bh_if #(.WIDTH(8))  if8  ();
    fa_bh_if #(.WIDTH(16)) if16 ();

    fa_bh #(.WIDTH(1)) u_dut1 (
        .s(if1.s), .c(if1.c), .a(if1.a), .b(if1.b), .cin(if1.cin),
        .clk(clk), .rst_n(rst_n), .in_valid(if1.in_valid), .out_valid(if1.out_valid)
    );
    fa_bh #(.WIDTH(8)) u_dut8 (
        .s(if8.s), .c(if8.c), .a(if8.a), .b(if8.b), .cin(if8.cin),
        .clk(clk), .rst_n(rst_n), .in_valid(if8.in_valid), .out_valid(if8.out_valid)
    );
    fa_bh #(.WIDTH(16)) u_dut16 (
        .s(if16.s), .c(if16.c), .a(if16.a), .b(if16.b), .cin(if16.cin),
        .clk(clk), .rst_n(rst_n), .in_valid(if16.in_valid), .out_valid(if16.out_valid)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference state per width slot: 0 -> WIDTH 1, 1 -> WIDTH 8, 2 -> WIDTH 16
    longint unsigned exp_s [3];
    logic            exp_c [3];
    logic            exp_v [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            exp_s[k] = 0;
            exp_c[k] = 1'b0;
            exp_v[k] = 1'b0;
        end
    endtask

    task automatic read_dut(input int w, output logic [63:0] gs, output logic gc, output logic gv);
        gs = '0;
        case (w)
            1: begin gs[0]    = if1.s;  gc = if1.c;  gv = if1.out_valid;  end
            8: begin gs[7:0]  = if8.s;  gc = if8.c;  gv = if8.out_valid;  end
            default: begin gs[15:0] = if16.s; gc = if16.c; gv = if16.out_valid; end
        endcase
    endtask

    task automatic check_dut(input int w, input string tag);
        logic [63:0] gs;
        logic        gc, gv;
        int          k;
        k = (w == 1) ? 0 : (w == 8) ? 1 : 2;
        read_dut(w, gs, gc, gv);
        chk({tag, "/s"},  gs, exp_s[k]);
        chk({tag, "/c"},  {63'd0, gc}, {63'd0, exp_c[k]});
        chk({tag, "/ov"}, {63'd0, gv}, {63'd0, exp_v[k]});
    endtask

    // One cycle: drive after negedge, let the edge sample, check 1 ns later.
    task automatic op(input int w, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic v, input string tag);
        longint unsigned mask, sum;
        int              k;
        @(negedge clk);
        case (w)
            1: begin if1.a = a[0:0]; if1.b = b[0:0]; if1.cin = cin; if1.in_valid = v; end
            8: begin if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.in_valid = v; end
            default: begin if16.a = a; if16.b = b; if16.cin = cin; if16.in_valid = v; end
        endcase
        @(posedge clk);
        #1;
        k    = (w == 1) ? 0 : (w == 8) ? 1 : 2;
        mask = (64'd1 << w) - 1;
        if (v) begin
            sum      = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
            exp_s[k] = sum & mask;
            exp_c[k] = sum[w];
        end
        exp_v[k] = v;
        check_dut(w, tag);
    endtask

    task automatic idle(input int w);
        @(negedge clk);
        case (w)
            1: if1.in_valid = 1'b0;
            8: if8.in_valid = 1'b0;
            default: if16.in_valid = 1'b0;
        endcase
    endtask

    initial begin
        if1.a  = '0; if1.b  = '0; if1.cin  = 1'b0; if1.in_valid  = 1'b0;
        if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0; if8.in_valid  = 1'b0;
        if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.in_valid = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_dut(1, "rst1");
        check_dut(8, "rst8");
        check_dut(16, "rst16");
        @(negedge clk);
        rst_n = 1'b1;

        // First operand after reset lands in one cycle
        op(1, 16'h0, 16'h0, 1'b0, 1'b1, "seq_000");
        op(1, 16'h1, 16'h0, 1'b0, 1'b1, "seq_100");
        op(1, 16'h1, 16'h1, 1'b0, 1'b1, "seq_110");
        op(1, 16'h1, 16'h1, 1'b1, 1'b1, "seq_111");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = i[2:0];
            op(1, {15'd0, abc[2]}, {15'd0, abc[1]}, abc[0], 1'b1, $sformatf("exh_%0d", i));
        end
        idle(1);

        op(8, 16'h00FF, 16'h0001, 1'b0, 1'b1, "wrap8");
        op(8, 16'h00FF, 16'h00FF, 1'b1, 1'b1, "max8");

        op(8, 16'h002D, 16'h002D, 1'b0, 1'b1, "hold_load");
        for (int i = 0; i < 3; i++)
            op(8, 16'hxxxx, 16'hxxxx, 1'bx, 1'b0, $sformatf("hold_%0d", i));

        // Asynchronous reset between edges while out_valid is high
        op(8, 16'h0010, 16'h0020, 1'b1, 1'b1, "pre_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dut(8, "async_rst");
        #1;
        rst_n = 1'b1;
        op(8, 16'h0012, 16'h0034, 1'b1, 1'b1, "post_rst");
        idle(8);

        op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b1, "wrap16");
        op(16, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "max16");
        for (int i = 0; i < 1000; i++) begin
            op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
               $sformatf("rnd_%0d", i));
        end
        idle(16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fa_bh
`default_nettype wire

// File: doc/fa_bh.md
FA_BH -- requirements
Module: fa_bh

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: s  output  WIDTH  registered sum.
REQ-005 Port: c  output  1  registered carry-out.
REQ-006 Port: a  input  WIDTH  addend A.
REQ-007 Port: b  input  WIDTH  addend B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: in_valid  input  1  operands valid this cycle.
REQ-010 Port: out_valid  output  1  s and c hold a fresh result.
REQ-011 Port declaration order: s, c, a, b, cin, clk, rst_n, in_valid, out_valid, so the first five ports match positional full-adder instantiation (s, c, a, b, cin).

Function
REQ-012 {c, s} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation.
REQ-013 The sum SHALL use a ripple-carry chain of WIDTH one-bit full-adder cells.
REQ-014 Each cell SHALL compute s_i = a_i XOR b_i XOR c_i and c_(i+1) = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)), with c_0 = cin.
REQ-015 Latency SHALL be 1 cycle: operands sampled at edge N with in_valid=1 appear on s/c at edge N and stay stable until the next accepted operand.
REQ-016 out_valid SHALL be registered and equal to in_valid sampled at the previous rising edge.
REQ-017 When in_valid=0 at an edge, s and c SHALL hold their previous values and out_valid SHALL go to 0.
REQ-018 Operands SHALL be accepted every cycle back-to-back, with no backpressure and no stall input.
REQ-019 Full-scale wrap-around: all-ones + 1 SHALL produce s=0 and c=1.
REQ-020 Maximum input, all-ones + all-ones + cin=1, SHALL produce s=all-ones and c=1.
REQ-021 X or Z on inputs while in_valid=0 SHALL NOT propagate to s, c or out_valid.

Reset
REQ-022 While rst_n=0: s=0, c=0, out_valid=0, asserted asynchronously without waiting for clk.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight result.
REQ-024 After rst_n deasserts, the first accepted operand SHALL produce its result after 1 cycle, with no extra warm-up cycles.
REQ-025 Reset removal SHALL be synchronised by the enclosing system; the block does not synchronise rst_n internally.

Structure
REQ-026 A shared package fa_pkg SHALL hold the WIDTH default and legal-range constants.
REQ-027 One sub-module, fa_cell, SHALL implement the one-bit combinational full adder (ports s, c, a, b, cin).
REQ-028 fa_bh SHALL instantiate WIDTH fa_cell instances through a generate loop, followed by one output register stage.
REQ-029 The design SHALL have no latches and no combinational path from the inputs to s, c or out_valid.

Verification
REQ-030 WIDTH=1, in_valid=1, {a,b,cin} stepped 000 -> 100 -> 110 -> 111, one per cycle: {s,c} one cycle later = 00, 10, 01, 11.
REQ-031 WIDTH=1, exhaustive 8 input combinations with in_valid=1: each result matches a+b+cin one cycle later; out_valid=1 throughout.
REQ-032 WIDTH=8, a=8'hFF, b=8'h01, cin=0: s=8'h00, c=1. Then a=8'hFF, b=8'hFF, cin=1: s=8'hFF, c=1.
REQ-033 in_valid=1 with result s=8'h5A, then in_valid=0 with random inputs for 3 cycles: s stays 8'h5A, out_valid=0.
REQ-034 rst_n pulsed low between clock edges while out_valid=1: s=0, c=0, out_valid=0 immediately; the next accepted operand yields the correct sum after 1 cycle.
REQ-035 Random WIDTH=16 stream of 1000 operands with in_valid toggling randomly: scoreboard {c,s} against a+b+cin with 1-cycle latency; zero mismatches.
